// File: rtl/capture_controller.sv
// Logic-analyzer capture sequencer: circular pre/post-trigger capture into the
// sample BRAM, then newest-first readout of the window to the UART.
module capture_controller #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    ext_reset,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    run,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic [15:0]             read_count,
  input  logic [15:0]             delay_count,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [SAMPLE_WIDTH-1:0] mem_wdata,
  input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
  output logic [SAMPLE_WIDTH-1:0] tx_data,
  output logic                    tx_start,
  input  logic                    transmit_busy,
  output logic                    capturing,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_LOAD,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_REQ,
    S_TX_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [15:0] C_ONE = 16'd1;
  // Readout can never exceed one full buffer.
  localparam logic [15:0] MAX_REM =
    16'((32'd1 << ADDR_WIDTH) - 32'd1);

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [15:0]             r_post_cnt;
  logic [15:0]             r_delay;
  logic [15:0]             r_read;
  logic [15:0]             r_remain;
  logic [SAMPLE_WIDTH-1:0] r_tx_data;
  logic                    r_tx_start;
  logic                    r_done;
  logic                    r_first;

  logic                  w_we;
  logic                  w_tx_go;
  logic                  w_last;
  logic                  w_step;
  logic                  w_post_done;
  logic [15:0]           w_clamp;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_post_done = (r_post_cnt == r_delay);
  assign w_clamp = (r_read > MAX_REM) ? MAX_REM : r_read;

  always_ff @(posedge clock or posedge ext_reset) begin
    if (ext_reset) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_tx_go = 1'b0;
    w_last  = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      S_IDLE: if (arm) w_next = S_ARMED;
      S_ARMED: begin
        w_we = sample_valid;
        if (run) w_next = S_POST;
      end
      S_POST: begin
        if (w_post_done) w_next = S_LOAD;
        else             w_we   = sample_valid;
      end
      S_LOAD:    w_next = S_RD_ADDR;
      S_RD_ADDR: w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_TX_REQ;
      S_TX_REQ: begin
        if (!transmit_busy) begin
          w_tx_go = 1'b1;
          w_next  = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // First cycle skipped: busy only rises the cycle after tx_start.
        if (!r_first && !transmit_busy) begin
          if (r_remain == 16'd0) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_step = 1'b1;
            w_next = S_RD_ADDR;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (reset) begin
      w_next  = S_IDLE;
      w_we    = 1'b0;
      w_tx_go = 1'b0;
      w_last  = 1'b0;
      w_step  = 1'b0;
    end
  end

  always_comb begin
    w_addr = '0;
    case (r_state)
      S_ARMED, S_POST: w_addr = r_wr_ptr;
      S_RD_ADDR, S_RD_WAIT,
      S_TX_REQ, S_TX_WAIT: w_addr = r_rd_ptr;
      default: w_addr = '0;
    endcase
  end

  always_ff @(posedge clock or posedge ext_reset) begin
    if (ext_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_delay    <= '0;
      r_read     <= '0;
      r_remain   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
    end else if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_delay    <= '0;
      r_read     <= '0;
      r_remain   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_tx_start <= w_tx_go;
      r_done     <= w_last;
      if (w_we) r_wr_ptr <= r_wr_ptr + A_ONE;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_read     <= read_count;
            r_delay    <= delay_count;
            r_wr_ptr   <= '0;
            r_post_cnt <= '0;
          end
        end
        S_POST: if (w_we) r_post_cnt <= r_post_cnt + C_ONE;
        S_LOAD: begin
          r_rd_ptr <= r_wr_ptr - A_ONE;
          r_remain <= w_clamp;
        end
        S_RD_WAIT: r_tx_data <= mem_rdata;
        S_TX_REQ:  if (w_tx_go) r_first <= 1'b1;
        S_TX_WAIT: begin
          r_first <= 1'b0;
          if (w_step) begin
            r_rd_ptr <= r_rd_ptr - A_ONE;
            r_remain <= r_remain - C_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = w_we;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_we ? sample_in : '0;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign done      = r_done;
  assign capturing = (r_state == S_ARMED) || (r_state == S_POST);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: BRAM and UART models, a window-level
// reference of the capture buffer, and one per-cycle compare process.
module tb_capture_controller;

  localparam int AW = 4;
  localparam int D  = 1 << AW;

  logic          clock = 1'b0;
  logic          ext_reset;
  logic          reset;
  logic          arm;
  logic          run;
  logic          sample_valid;
  logic [7:0]    sample_in;
  logic [15:0]   read_count;
  logic [15:0]   delay_count;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          transmit_busy;
  logic          capturing;
  logic          busy;
  logic          done;

  capture_controller #(
    .SAMPLE_WIDTH(8),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock),
    .ext_reset(ext_reset),
    .reset(reset),
    .arm(arm),
    .run(run),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .read_count(read_count),
    .delay_count(delay_count),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .transmit_busy(transmit_busy),
    .capturing(capturing),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read BRAM
  logic [7:0] bram [D];
  always @(posedge clock) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  // UART: busy from the cycle after tx_start, for busy_len cycles
  int ub_cnt = 0;
  int busy_len = 4;
  always @(posedge clock) begin
    if (tx_start)       ub_cnt <= busy_len;
    else if (ub_cnt > 0) ub_cnt <= ub_cnt - 1;
  end
  assign transmit_busy = (ub_cnt != 0);

  // Reference model state
  logic [7:0]      exp_mem [D];
  logic [AW+7:0]   wq[$];
  logic [7:0]      bq[$];
  logic [7:0]      sent[$];
  logic [AW+7:0]   we_exp;
  logic [7:0]      tx_exp;
  logic [7:0]      held;
  int              wcnt;
  bit              m_reading;
  int              checks = 0;
  int              fails = 0;
  int              done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!ext_reset) begin
      if (mem_we) begin
        chk("wr_expected", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          we_exp = wq.pop_front();
          chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(we_exp));
        end
      end
      if (tx_start) begin
        chk("tx_while_busy", 32'(transmit_busy), 0);
        chk("tx_expected", 32'(bq.size() != 0), 1);
        if (bq.size() != 0) begin
          tx_exp = bq.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(tx_exp));
        end
        sent.push_back(tx_data);
        held = tx_data;
      end else if (m_reading && transmit_busy) begin
        chk("tx_stable", 32'(tx_data), 32'(held));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cycle(input bit v, input logic [7:0] d,
                             input bit expect_wr);
    sample_valid = v;
    sample_in    = d;
    if (v && expect_wr) begin
      wq.push_back({AW'(wcnt % D), d});
      exp_mem[wcnt % D] = d;
      wcnt++;
    end
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_capturing"}, 32'(capturing), 0);
    chk({tag, "_mem_we"},    32'(mem_we), 0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 0);
    chk({tag, "_tx_start"},  32'(tx_start), 0);
    chk({tag, "_tx_data"},   32'(tx_data), 0);
    chk({tag, "_done"},      32'(done), 0);
  endtask

  task automatic capture(input int pre_n, input int dly, input int rc,
                         input int blen, input bit rnd_v, input bit rnd_d,
                         input logic [7:0] base, input int rst_after);
    int got;
    int idx;
    int n;
    int start;
    bit v;
    logic [7:0] d;
    busy_len = blen;
    sent.delete();
    wcnt = 0;
    idx = 0;
    read_count  = 16'(rc);
    delay_count = 16'(dly);
    arm = 1'b1;
    run = 1'b0;
    drive_cycle(1'b0, 8'h00, 1'b0);
    arm = 1'b0;
    read_count  = 16'($urandom);
    delay_count = 16'($urandom);
    chk("armed_capturing", 32'(capturing), 1);
    chk("armed_busy", 32'(busy), 1);
    got = 0;
    while (got < pre_n) begin
      v = rnd_v ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rnd_d ? 8'($urandom) : base + 8'(idx);
      run = v && (got == pre_n - 1);
      arm = rnd_v && !run && ($urandom_range(0, 7) == 0);
      drive_cycle(v, d, 1'b1);
      if (v) begin
        got++;
        idx++;
      end
    end
    arm = 1'b0;
    got = 0;
    while (got < dly) begin
      v = rnd_v ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = rnd_d ? 8'($urandom) : base + 8'(idx);
      drive_cycle(v, d, 1'b1);
      if (v) begin
        got++;
        idx++;
      end
    end
    // Delay satisfied: this cycle must not write
    drive_cycle(1'b1, 8'($urandom), 1'b0);
    run = 1'b0;
    chk("capture_ended", 32'(capturing), 0);
    chk("writes_done", 32'(wq.size()), 0);
    n = ((rc > D - 1) ? D - 1 : rc) + 1;
    for (int k = 0; k < n; k++)
      bq.push_back(exp_mem[((wcnt - 1 - k) % D + D) % D]);
    m_reading = 1'b1;
    start = done_cnt;
    for (int i = 0; i < 4000 && done_cnt == start; i++) begin
      if (rst_after > 0 && sent.size() == rst_after) begin
        drive_cycle(1'b0, 8'h00, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        drive_cycle(1'b1, 8'h5A, 1'b0);
        reset = 1'b0;
        m_reading = 1'b0;
        bq.delete();
        chk_idle("srst_tx");
        for (int j = 0; j < 30; j++) drive_cycle(1'b0, 8'h00, 1'b0);
        chk("srst_tx_nodone", done_cnt - start, 0);
        chk("srst_tx_nosend", sent.size(), rst_after);
        return;
      end
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    chk("done_seen", done_cnt - start, 1);
    chk("idle_after_done", 32'(busy), 0);
    m_reading = 1'b0;
    repeat (3) drive_cycle(1'b0, 8'h00, 1'b0);
    chk("done_once", done_cnt - start, 1);
    chk("bytes_sent", sent.size(), n);
    chk("bytes_left", bq.size(), 0);
  endtask

  initial begin
    int rc;
    ext_reset = 1'b1;
    reset = 1'b0;
    arm = 1'b0;
    run = 1'b0;
    sample_valid = 1'b0;
    sample_in = 8'h00;
    read_count = 16'h0;
    delay_count = 16'h0;
    mem_rdata = 8'h00;
    m_reading = 1'b0;
    wcnt = 0;
    for (int i = 0; i < D; i++) begin
      bram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    repeat (2) @(posedge clock);
    #1;
    chk_idle("por");
    ext_reset = 1'b0;
    tick();

    // Basic: 0x10..0x13 pre, 0x14..0x17 post
    capture(4, 4, 7, 3, 1'b0, 1'b0, 8'h10, 0);
    chk("basic_n", sent.size(), 8);
    chk("basic_first", 32'(sent[0]), 32'h17);
    chk("basic_last", 32'(sent[7]), 32'h10);
    chk("basic_mem0", 32'(bram[0]), 32'h10);
    chk("basic_mem7", 32'(bram[7]), 32'h17);

    // Wrap: 20 pre + 2 post in a 16-deep buffer
    capture(20, 2, 15, 2, 1'b0, 1'b0, 8'h00, 0);
    chk("wrap_n", sent.size(), 16);
    chk("wrap_first", 32'(sent[0]), 32'h15);
    chk("wrap_last", 32'(sent[15]), 32'h06);

    // No post-trigger samples, one byte back
    capture(1, 0, 0, 1, 1'b0, 1'b0, 8'hA5, 0);
    chk("d0_n", sent.size(), 1);
    chk("d0_byte", 32'(sent[0]), 32'hA5);

    // Slow transmitter
    capture(6, 2, 5, 10, 1'b1, 1'b1, 8'h00, 0);

    // Clamp to buffer depth
    capture(5, 3, 16'hFFFF, 2, 1'b1, 1'b1, 8'h00, 0);
    chk("clamp_n", sent.size(), 16);

    // Soft reset in post-trigger phase
    wcnt = 0;
    read_count = 16'd5;
    delay_count = 16'd10;
    arm = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0);
    arm = 1'b0;
    drive_cycle(1'b1, 8'h31, 1'b1);
    drive_cycle(1'b1, 8'h32, 1'b1);
    run = 1'b1;
    drive_cycle(1'b1, 8'h33, 1'b1);
    drive_cycle(1'b1, 8'h34, 1'b1);
    drive_cycle(1'b1, 8'h35, 1'b1);
    chk("srst_post_pre", 32'(capturing), 1);
    reset = 1'b1;
    drive_cycle(1'b1, 8'h36, 1'b0);
    reset = 1'b0;
    run = 1'b0;
    chk_idle("srst_post");
    begin
      int s0;
      s0 = done_cnt;
      for (int j = 0; j < 20; j++) drive_cycle(1'b1, 8'h77, 1'b0);
      chk("srst_post_nodone", done_cnt - s0, 0);
    end

    // Soft reset while waiting on the UART
    capture(6, 2, 9, 10, 1'b1, 1'b1, 8'h00, 2);

    // Asynchronous reset mid-capture
    wcnt = 0;
    read_count = 16'd3;
    delay_count = 16'd2;
    arm = 1'b1;
    drive_cycle(1'b0, 8'h00, 1'b0);
    arm = 1'b0;
    drive_cycle(1'b1, 8'h41, 1'b1);
    drive_cycle(1'b1, 8'h42, 1'b1);
    sample_valid = 1'b0;
    chk("xrst_pre", 32'(capturing), 1);
    #2;
    ext_reset = 1'b1;
    #1;
    chk_idle("xrst");
    @(posedge clock);
    #1;
    ext_reset = 1'b0;
    tick();

    // Randomized captures
    for (int r = 0; r < 10; r++) begin
      rc = ($urandom_range(0, 4) == 0) ? 16'hFFFF : $urandom_range(0, 20);
      capture($urandom_range(1, 25), $urandom_range(0, 6), rc,
              $urandom_range(1, 12), 1'b1, 1'b1, 8'h00, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Sequences the sample buffer RAM for the logic analyzer. It captures divided samples into a circular buffer after arm, then captures a programmed number of post-trigger samples once `run` asserts. It then streams the captured window to the UART transmitter, newest sample first.
- Sits between the top-level command controller (arm/reset), the trigger unit (`run`), the sample-rate divider (`sample_valid`), the buffer BRAM, and the data side of the data/meta transmit mux.

Parameters:
- SAMPLE_WIDTH, 8, width of one sample; equals the UART byte width.
- ADDR_WIDTH, 10, buffer address width; depth = 2^ADDR_WIDTH.

Ports:
- clock  in  1  system clock.
- ext_reset  in  1  asynchronous active-high reset.
- reset  in  1  synchronous soft reset pulse from command controller (opcode 0x00).
- arm  in  1  one-cycle pulse; starts a capture.
- run  in  1  trigger-fired level from trigger unit.
- sample_valid  in  1  one-cycle strobe from divider; a new sample is present.
- sample_in  in  SAMPLE_WIDTH  current sample.
- read_count  in  16  total samples to return, minus 1.
- delay_count  in  16  post-trigger samples to capture.
- mem_we  out  1  buffer write enable.
- mem_addr  out  ADDR_WIDTH  buffer address.
- mem_wdata  out  SAMPLE_WIDTH  buffer write data.
- mem_rdata  in  SAMPLE_WIDTH  buffer read data, valid 1 cycle after address.
- tx_data  out  SAMPLE_WIDTH  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- transmit_busy  in  1  UART busy; asserts the cycle after tx_start and stays high until the byte completes.
- capturing  out  1  high in ARMED and POST_TRIG.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset values (`ext_reset` or soft `reset`): state IDLE, all outputs 0, wr_ptr/rd_ptr/counters 0.
- Soft `reset` acts synchronously and wins over every other input in any state, including mid-capture and mid-transmit. A tx_start already issued is not retracted.
- IDLE:
  - `arm` = 1 latches read_count and delay_count, clears wr_ptr and post_cnt, and goes to ARMED.
  - Other inputs are ignored.
- ARMED:
  - On each `sample_valid`: mem_we = 1, mem_addr = wr_ptr, mem_wdata = sample_in in the same cycle; wr_ptr increments and wraps modulo 2^ADDR_WIDTH.
  - `run` = 1 goes to POST_TRIG. A sample written in the trigger cycle counts as pre-trigger.
  - `arm` is ignored.
- POST_TRIG:
  - Writes as in ARMED; each write increments post_cnt.
  - When post_cnt == delay_count (checked every cycle, including entry), go to LOAD and perform no write that cycle.
  - delay_count = 0 means no post-trigger samples are captured.
- LOAD (1 cycle):
  - rd_ptr = wr_ptr − 1 (wrapping).
  - remaining = min(read_count, 2^ADDR_WIDTH − 1).
  - Go to RD_ADDR.
- RD_ADDR: mem_addr = rd_ptr, mem_we = 0; go to RD_WAIT.
- RD_WAIT: latch tx_data ← mem_rdata; go to TX_REQ.
- TX_REQ:
  - When transmit_busy = 0: tx_start = 1 for exactly one cycle, then go to TX_WAIT.
  - Otherwise hold.
- TX_WAIT:
  - Skip the first cycle.
  - Afterwards, when transmit_busy = 0: if remaining == 0, pulse done and go to IDLE; otherwise rd_ptr decrements (wrapping), remaining decrements, and go to RD_ADDR.
- Bytes sent = clamped remaining + 1. Order is newest first; the SUMP host reverses.
- If fewer samples were written than requested, stale or zero buffer contents are sent anyway; no underflow flag.
- tx_data is held stable from TX_REQ through the end of TX_WAIT.
- mem_addr: wr_ptr in ARMED/POST_TRIG, rd_ptr in read states, 0 otherwise.
- capturing, busy and mem_we are combinational from state; tx_start and done are registered.
- Throughput: at most 1 sample write per cycle; `sample_valid` every cycle is supported.

Test Plan:
- Basic capture: arm; 8 samples 0x10..0x17 with run rising after 0x13; delay_count = 4, read_count = 7 → memory 0..7 = 0x10..0x17; bytes sent 0x17,0x16,…,0x10 (8 tx_start pulses); done pulses once; busy returns 0.
- Wrap: ADDR_WIDTH = 4; 20 pre-trigger samples 0x00..0x13, run, delay_count = 2 (0x14, 0x15), read_count = 15 → sends 0x15 down to 0x06; wr_ptr wraps cleanly.
- delay_count = 0: run asserted during the cycle 0xA5 is written, read_count = 0 → exactly one byte 0xA5 sent; no post-trigger writes.
- Busy handshake: transmitter holds busy 10 cycles per byte → exactly one tx_start per byte; tx_start never asserts while busy = 1; tx_data stable throughout.
- Clamp: ADDR_WIDTH = 4, read_count = 0xFFFF → exactly 16 bytes sent.
- Reset mid-operation: soft reset during POST_TRIG and again during TX_WAIT → IDLE next cycle, all outputs 0, no done. `ext_reset` asserted asynchronously mid-capture → outputs 0 immediately. A new arm afterwards works normally.
